// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, flag vector layout, FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_ORR  = 3'b011,
        OP_EOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier datapath: load latches operands, each step retires one bit.
// prod is the accumulator value after the current step, so the caller can capture it on the last step.
module mul_iter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] prod,
    output logic         last
);

    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]     acc;
    logic [N-1:0]     mplier;
    logic [N-1:0]     mcand;
    logic [CNT_W-1:0] cnt;

    // Only the low N bits of the product are kept, so the shifted multiplier may drop its top bits.
    assign prod = acc + (mcand[0] ? mplier : '0);
    assign last = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mplier <= '0;
            mcand  <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mplier <= a;
            mcand  <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= prod;
            mplier <= mplier << 1;
            mcand  <= mcand >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic ops, N-cycle shift-add MUL, registered NZCV flags.
// ready drops only while a multiply is in flight; starts seen while busy are dropped, not queued.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   alu_ctl,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    state_t     state;
    state_t     state_next;
    alu_op_t    op;

    logic         is_sub;
    logic [N-1:0] bb;
    logic [N:0]   sum;
    logic [N-1:0] sc_result;
    logic         sc_c;
    logic         sc_v;

    logic         mul_load;
    logic         mul_step;
    logic [N-1:0] mul_prod;
    logic         mul_last;

    logic         cmp_en;
    logic [N-1:0] cmp_result;
    alu_flags_t   cmp_flags;

    assign op    = alu_op_t'(alu_ctl);
    assign ready = (state == IDLE);

    // SUB reuses the adder with inverted b and carry-in 1, so C comes out as not-borrow.
    always_comb begin
        is_sub    = (op == OP_SUB);
        bb        = is_sub ? ~b : b;
        sum       = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, is_sub};
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_result = sum[N-1:0];
                sc_c      = sum[N];
                sc_v      = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_AND:  sc_result = a & b;
            OP_ORR:  sc_result = a | b;
            OP_EOR:  sc_result = a ^ b;
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        cmp_en     = 1'b0;
        cmp_result = '0;
        cmp_flags  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_load   = 1'b1;
                        state_next = BUSY;
                    end else begin
                        cmp_en      = 1'b1;
                        cmp_result  = sc_result;
                        cmp_flags.c = sc_c;
                        cmp_flags.v = sc_v;
                    end
                end
            end
            BUSY: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    cmp_en     = 1'b1;
                    cmp_result = mul_prod;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        cmp_flags.n = cmp_result[N-1];
        cmp_flags.z = (cmp_result == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            state <= state_next;
            done  <= cmp_en;
            if (cmp_en) begin
                result <= cmp_result;
                flags  <= cmp_flags;
            end
        end
    end

    mul_iter #(.N(N)) u_mul_iter (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load),
        .step  (mul_step),
        .a     (a),
        .b     (b),
        .prod  (mul_prod),
        .last  (mul_last)
    );

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at N=8; inputs change and outputs are sampled on the falling edge.
module tb_alu_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] alu_ctl;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic [3:0] flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_multicycle #(.N(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .alu_ctl (alu_ctl),
        .ready   (ready),
        .done    (done),
        .result  (result),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic s, input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
        start   = s;
        alu_ctl = op;
        a       = va;
        b       = vb;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result got %h exp 00", result); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp 0000", flags); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        drive(1'b1, 3'b000, 8'h7F, 8'h01);
        @(negedge clk);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        n_cmp++; if (result !== 8'h80) begin n_err++; $display("FAIL add_result got %h exp 80", result); end
        n_cmp++; if (flags !== 4'b1001) begin n_err++; $display("FAIL add_flags got %b exp 1001", flags); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL add_done got %b exp 1", done); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL add_ready got %b exp 1", ready); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b exp 0", done); end
        n_cmp++; if (result !== 8'h80) begin n_err++; $display("FAIL add_hold got %h exp 80", result); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 3'b001, 8'h05, 8'h05);
        @(negedge clk);
        n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL sub0_result got %h exp 00", result); end
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL sub0_flags got %b exp 0110", flags); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sub0_done got %b exp 1", done); end
        drive(1'b1, 3'b001, 8'h00, 8'h01);
        @(negedge clk);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        n_cmp++; if (result !== 8'hFF) begin n_err++; $display("FAIL sub1_result got %h exp ff", result); end
        n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL sub1_flags got %b exp 1000", flags); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sub1_done got %b exp 1", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL sub1_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_mul;
        logic [7:0] va [2]    = '{8'h0D, 8'hFF};
        logic [7:0] vb [2]    = '{8'h0B, 8'hFF};
        logic [7:0] exp_r [2] = '{8'h8F, 8'h01};
        logic [3:0] exp_f [2] = '{4'b1000, 4'b0000};
        logic [7:0] prev;
        int         busy_bad;
        for (int k = 0; k < 2; k++) begin
            prev = result;
            busy_bad = 0;
            drive(1'b1, 3'b101, va[k], vb[k]);
            @(negedge clk);
            drive(1'b0, 3'b000, 8'h00, 8'h00);
            for (int i = 0; i < 8; i++) begin
                if (ready !== 1'b0 || done !== 1'b0 || result !== prev) busy_bad++;
                if (i < 7) @(negedge clk);
            end
            n_cmp++; if (busy_bad != 0) begin n_err++; $display("FAIL mul%0d_busy %0d bad busy cycles exp 0", k, busy_bad); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mul%0d_done got %b exp 1", k, done); end
            n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mul%0d_ready got %b exp 1", k, ready); end
            n_cmp++; if (result !== exp_r[k]) begin n_err++; $display("FAIL mul%0d_result got %h exp %h", k, result, exp_r[k]); end
            n_cmp++; if (flags !== exp_f[k]) begin n_err++; $display("FAIL mul%0d_flags got %b exp %b", k, flags, exp_f[k]); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mul%0d_done_pulse got %b exp 0", k, done); end
        end
    endtask

    task automatic test_ignored_start;
        int done_cnt = 0;
        int done_at  = -1;
        drive(1'b1, 3'b101, 8'h0D, 8'h0B);
        @(negedge clk);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            if (done === 1'b1) begin done_cnt++; done_at = i; end
            if (i == 2) drive(1'b1, 3'b000, 8'h01, 8'h01);
            if (i == 3) drive(1'b0, 3'b000, 8'h00, 8'h00);
            @(negedge clk);
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ign_done_count got %0d exp 1", done_cnt); end
        n_cmp++; if (done_at != 9) begin n_err++; $display("FAIL ign_done_cycle got %0d exp 9", done_at); end
        n_cmp++; if (result !== 8'h8F) begin n_err++; $display("FAIL ign_result got %h exp 8f", result); end
        n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL ign_flags got %b exp 1000", flags); end
    endtask

    task automatic test_reset_mid_mul;
        int done_cnt = 0;
        drive(1'b1, 3'b101, 8'h0D, 8'h0B);
        @(negedge clk);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b exp 0", ready); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b exp 1", ready); end
        n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL rst_mid_result got %h exp 00", result); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags got %b exp 0000", flags); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b exp 0", done); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rst_mid_stray_done got %0d exp 0", done_cnt); end
        drive(1'b1, 3'b000, 8'h03, 8'h04);
        @(negedge clk);
        drive(1'b0, 3'b000, 8'h00, 8'h00);
        n_cmp++; if (result !== 8'h07) begin n_err++; $display("FAIL rst_add_result got %h exp 07", result); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_add_flags got %b exp 0000", flags); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rst_add_done got %b exp 1", done); end
    endtask

    task automatic test_logic_reserved;
        logic [2:0] ops [5]   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
        logic [7:0] va [5]    = '{8'h05, 8'hF0, 8'hF0, 8'hAA, 8'h55};
        logic [7:0] vb [5]    = '{8'h05, 8'h0F, 8'h0F, 8'hFF, 8'h33};
        logic [7:0] exp_r [5] = '{8'h00, 8'h00, 8'hFF, 8'h55, 8'h00};
        logic [3:0] exp_f [5] = '{4'b0110, 4'b0100, 4'b1000, 4'b0000, 4'b0100};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ops[k], va[k], vb[k]);
            @(negedge clk);
            drive(1'b0, 3'b000, 8'h00, 8'h00);
            n_cmp++; if (result !== exp_r[k]) begin n_err++; $display("FAIL logic%0d_result got %h exp %h", k, result, exp_r[k]); end
            n_cmp++; if (flags !== exp_f[k]) begin n_err++; $display("FAIL logic%0d_flags got %b exp %b", k, flags, exp_f[k]); end
            n_cmp++; if (done !== 1'b1 || ready !== 1'b1) begin n_err++; $display("FAIL logic%0d_handshake got done=%b ready=%b exp 1 1", k, done, ready); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_ignored_start();
        test_reset_mid_mul();
        test_logic_reserved();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle ALU for the datapath. It executes ADD/SUB/AND/ORR/EOR in one registered cycle and MUL as an N-iteration shift-add sequence. Every completed operation produces an NZCV flag vector. Sits in the execute stage behind a start/ready/done handshake, so the control unit can stall on multiplies.

## Interface
Parameters:
- N, default 32, operand/result width (≥ 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; accepted only when ready=1
- a, b  in  N  operands, sampled at the accepting edge
- alu_ctl  in  3  op code, sampled at the accepting edge
- ready  out  1  high in IDLE
- done  out  1  one-cycle completion pulse
- result  out  N  registered result, held until next completion
- flags  out  4  registered {N,Z,C,V}, held until next completion

## Operation
- Op codes (alu_op_t):
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 ORR
  - 100 EOR
  - 101 MUL
  - 110/111 reserved
- Reserved codes are single-cycle: result=0, flags=0100.
- ADD/SUB form sum[N:0] = a + (sub ? ~b : b) + sub.
  - result = sum[N-1:0]
  - C = sum[N]; for SUB this is the not-borrow convention
  - V = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]), where bb is the conditionally inverted b
- Logic ops and MUL: C=0, V=0.
- All ops: N = result[N-1], Z = (result == 0).
- MUL returns the low N bits of a*b (identical for signed and unsigned operands).
  - Algorithm: radix-2 shift-add over a fixed N iterations, no early termination.
  - Each iteration: if mcand_lsb, acc += mplier; then mplier <<= 1, mcand >>= 1.
- FSM:
  - IDLE: start & single-cycle op → register result/flags/done, stay IDLE. start & MUL → latch operands, clear acc, cnt=0, go BUSY.
  - BUSY: one iteration per edge, cnt++. On the Nth iteration → register result/flags, done=1, go IDLE.
- start while BUSY is ignored; it is not queued.

## Timing
- Reset values (asynchronous): state=IDLE, ready=1, done=0, result=0, flags=0000, cnt=0, acc=0.
- Accepting edge E0 is the edge with start=1 and ready=1.
- Single-cycle ops:
  - result, flags and done are valid in the cycle after E0.
  - ready stays 1, so back-to-back starts give one result per cycle.
- MUL:
  - ready=0 from E0 until EN (the Nth edge after E0).
  - done, result and flags are valid in the cycle after EN, with ready=1 in the same cycle.
  - The earliest next accept is EN+1, so throughput is one MUL per N+1 cycles.
- done is high for exactly one cycle per accepted op. It is never asserted for an ignored start.
- result/flags do not change during BUSY; intermediate acc is never visible.
- Reset mid-MUL: the FSM returns to IDLE immediately, no done is produced, and result/flags clear to 0.
- cnt width is $clog2(N+1); cnt must not wrap within one MUL.

## Structure
- alu_pkg:
  - typedef enum logic [2:0] alu_op_t
  - typedef struct packed {n, z, c, v} alu_flags_t
  - typedef enum state_t {IDLE, BUSY}
- Sub-module mul_iter (parameter N) contains the multiplier datapath: acc, shifted mcand/mplier registers and cnt, with a load/step interface and a last-iteration output.
- The top level owns the FSM, the single-cycle datapath, flag generation and output registers.

## Test plan
All scenarios use N=8.
- ADD a=0x7F, b=0x01, start at E0 → cycle after E0: result=0x80, flags=1001, done=1 for one cycle, ready stays 1.
- SUB 0x05−0x05 → 0x00, flags=0110. Then SUB 0x00−0x01 on the next cycle (back-to-back) → 0xFF, flags=1000.
- MUL 0x0D×0x0B → ready=0 for 8 cycles; result=0x8F, flags=1000, done in the cycle after E8. MUL 0xFF×0xFF → 0x01, flags=0000.
- Pulse start with ADD at E2 during a MUL → ignored: exactly one done, for the MUL, and the MUL result is unchanged.
- Assert reset after the third MUL iteration → ready=1 immediately, result=0, flags=0000, no done. Then ADD 0x03+0x04 → 0x07.
- A SUB leaving C=1, then AND 0xF0&0x0F → 0x00, flags=0100 (C and V cleared). Then alu_ctl=111 → 0x00, flags=0100, single-cycle.
